reg_file_scoreboard: RTL
========================

REG_FILE_SCOREBOARD -- requirements
Module: reg_file_scoreboard

Interface
REQ-001 The block SHALL expose the following ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- RegWriteW  in  1  writeback write enable.
- rdW  in  5  writeback destination register.
- ResultW  in  32  writeback data.
- rs1D, rs2D  in  5 each  decode-stage source register addresses.
- issueD  in  1  instruction in decode advances to EX this cycle.
- RegWriteD  in  1  issuing instruction writes a register.
- rdD  in  5  issuing instruction destination.
- flushE  in  1  instruction issued in the previous cycle is killed.
- RD1D, RD2D  out  32 each  read data for rs1D and rs2D.
- stallD  out  1  decode must hold; a source has an outstanding writer.
- sbErr  out  1  sticky scoreboard consistency error.

Function
REQ-002 The block SHALL hold 31 writable 32-bit registers x1..x31; x0 SHALL always read 0 and SHALL ignore writes.
REQ-003 On a rising edge with RegWriteW=1 and rdW!=0, ResultW SHALL be written to register rdW.
REQ-004 RD1D/RD2D SHALL be combinational; when RegWriteW=1, rdW!=0 and rdW equals the read address, the output SHALL be ResultW (write-through), else the stored value.
REQ-005 The block SHALL keep a 2-bit in-flight writer count per register x1..x31; count for x0 SHALL be constant 0.
REQ-006 Increment: issueD=1, RegWriteD=1, rdD!=0 SHALL add 1 to cnt[rdD] at the edge.
REQ-007 Decrement: RegWriteW=1, rdW!=0 SHALL subtract 1 from cnt[rdW] at the edge.
REQ-008 The block SHALL register the last issue as lastV (issueD&RegWriteD&rdD!=0) and lastRd (rdD) every cycle; flushE=1 with lastV=1 SHALL subtract 1 from cnt[lastRd] at the edge; flushE with lastV=0 SHALL have no effect.
REQ-009 All increments and decrements hitting one register in the same cycle SHALL be summed (net change range -2..+1) and applied once.
REQ-010 A net result above 3 SHALL saturate at 3 and set sbErr; a net result below 0 SHALL clamp at 0 and set sbErr.
REQ-011 sbErr SHALL remain 1 until reset.
REQ-012 stallD SHALL be 1 when, for rs1D or rs2D nonzero, cnt[rs]!=0, except when cnt[rs]==1 and RegWriteW=1 with rdW==rs in the same cycle (the write-through covers it).
REQ-013 stallD SHALL be combinational, with no added latency; the block SHALL NOT gate issueD with stallD (the caller does).
REQ-014 Read-after-write latency SHALL be 0 cycles via write-through; register contents SHALL update 1 edge after the write.

Reset
REQ-015 reset=0 SHALL asynchronously clear all registers x1..x31, all counts, lastV, lastRd and sbErr to 0.
REQ-016 During and directly after reset: RD1D=RD2D=0, stallD=0 and sbErr=0.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight counts; no pending write SHALL survive reset.

Verification
REQ-018 Write x5=0xDEADBEEF, then read rs1D=5 next cycle -> RD1D=0xDEADBEEF; write x0=0x1234 -> RD1D for rs1D=0 stays 0.
REQ-019 Same-cycle write x7=0xA5A5A5A5 with rs2D=7 -> RD2D=0xA5A5A5A5 combinationally, before the edge.
REQ-020 Issue rdD=3 (cnt=1), next cycle rs1D=3 -> stallD=1; cycle with RegWriteW rdW=3 -> stallD=0 and RD1D=ResultW; cnt=0 afterwards.
REQ-021 Issue rdD=9, next cycle flushE=1 -> cnt[9] returns to 0, stallD=0 for rs1D=9, sbErr=0.
REQ-022 Issue rdD=4 four times with no writeback -> cnt saturates at 3 and sbErr=1; writeback rdW=4 with cnt=0 after reset -> cnt stays 0 and sbErr=1.
REQ-023 Issue rdD=6 and writeback rdW=6 in the same cycle with cnt=1 -> cnt stays 1; assert reset=0 mid-run -> all counts 0, stallD=0, sbErr=0, all reads 0.

Source files
------------

// File: rtl/reg_file_scoreboard.sv
// Register file (x0..x31) with write-through reads and a per-register in-flight
// writer scoreboard that drives a combinational decode stall and a sticky error flag.
module reg_file_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteW,
  input  logic [4:0]  rdW,
  input  logic [31:0] ResultW,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic        issueD,
  input  logic        RegWriteD,
  input  logic [4:0]  rdD,
  input  logic        flushE,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic        stallD,
  output logic        sbErr
);

  logic [31:0] regs_q [1:31];
  logic [31:0] regs_d [1:31];
  logic [1:0]  cnt_q  [1:31];
  logic [1:0]  cnt_d  [1:31];
  logic [31:1] cnt_err;
  logic        last_v_q, last_v_d;
  logic [4:0]  last_rd_q, last_rd_d;
  logic        sb_err_q, sb_err_d;

  logic issue_wr, wb_wr, flush_wr;

  assign issue_wr = issueD & RegWriteD & (rdD != 5'd0);
  assign wb_wr    = RegWriteW & (rdW != 5'd0);
  assign flush_wr = flushE & last_v_q;

  // Net change of one counter; returns {error, new_count} with saturation/clamping.
  function automatic logic [2:0] apply_delta(input logic [1:0] cnt, input logic up,
                                             input logic [1:0] down);
    logic [2:0] total;
    logic [2:0] diff;
    total = {1'b0, cnt} + {2'b00, up};
    diff  = total - {1'b0, down};
    if (total < {1'b0, down})
      apply_delta = {1'b1, 2'd0};
    else if (diff > 3'd3)
      apply_delta = {1'b1, 2'd3};
    else
      apply_delta = {1'b0, diff[1:0]};
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] a);
    if (a == 5'd0)
      read_reg = '0;
    else if (wb_wr && (rdW == a))
      read_reg = ResultW;
    else
      read_reg = regs_q[a];
  endfunction

  // A single outstanding writer retiring this very cycle is covered by write-through.
  function automatic logic src_stall(input logic [4:0] a);
    if (a == 5'd0)
      src_stall = 1'b0;
    else
      src_stall = (cnt_q[a] != 2'd0) &&
                  !((cnt_q[a] == 2'd1) && wb_wr && (rdW == a));
  endfunction

  always_comb begin
    last_v_d  = issue_wr;
    last_rd_d = rdD;
    cnt_err   = '0;
    for (int i = 1; i < 32; i++) begin
      regs_d[i] = (wb_wr && (rdW == 5'(i))) ? ResultW : regs_q[i];
      {cnt_err[i], cnt_d[i]} = apply_delta(
        cnt_q[i],
        issue_wr && (rdD == 5'(i)),
        {1'b0, wb_wr && (rdW == 5'(i))} + {1'b0, flush_wr && (last_rd_q == 5'(i))});
    end
    sb_err_d = sb_err_q | (|cnt_err);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      last_v_q  <= 1'b0;
      last_rd_q <= '0;
      sb_err_q  <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      cnt_q     <= cnt_d;
      last_v_q  <= last_v_d;
      last_rd_q <= last_rd_d;
      sb_err_q  <= sb_err_d;
    end
  end

  // Outputs are forced quiet while reset is held so no stale write-through leaks out.
  assign RD1D   = reset ? read_reg(rs1D) : '0;
  assign RD2D   = reset ? read_reg(rs2D) : '0;
  assign stallD = reset & (src_stall(rs1D) | src_stall(rs2D));
  assign sbErr  = sb_err_q;

endmodule
